// File: rtl/rx_nibble_chunker.sv
// rx_nibble_chunker: packs rx_mac nibbles into fixed-width chunks behind a FWFT queue; CHUNKER_STATS_EN adds pkt_cnt/drop_cnt.
module rx_nibble_chunker #(
  parameter int CHUNK_BYTES = 15,
  parameter int DEPTH = 4,
  localparam int SW = CHUNK_BYTES > 1 ? $clog2(CHUNK_BYTES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [3:0]               in_dat,
  input  logic                     in_eof,
  output logic                     out_vld,
  output logic [8*CHUNK_BYTES-1:0] out_dat,
  output logic [SW-1:0]            out_size,
  output logic                     out_eof,
  output logic                     out_err,
`ifdef CHUNKER_STATS_EN
  output logic [31:0]              pkt_cnt,
  output logic [31:0]              drop_cnt,
`endif
  input  logic                     out_ack
);
  localparam int NB = 2 * CHUNK_BYTES;
  localparam int NW = NB > 1 ? $clog2(NB) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 8 * CHUNK_BYTES;
  typedef enum logic [1:0] {PACK, DROP, FLUSH_ERR, SKIP} state_t;
  state_t state, state_nx;
  logic [NW-1:0] n;
  logic [DW-1:0] hold, chunk, p_dat;
  logic [SW-1:0] p_size;
  logic p_eof, p_err, push, pop, space, done, last, flush, pack_ok;
  logic fresh, pend, pend_eof, pend_cur, eof_seen;
  logic [AW:0] count;
  logic [AW-1:0] wp, rp;
  logic [DW-1:0] q_dat [DEPTH];
  logic [SW-1:0] q_size [DEPTH];
  logic q_eof [DEPTH];
  logic q_err [DEPTH];
  assign last = n == NW'(NB - 1);
  assign done = in_vld && (in_eof || last);
  assign flush = state == FLUSH_ERR;
  // fresh marks the first edge after reset; a nibble seen there belongs to a packet already in flight
  assign pack_ok = state == PACK && !fresh;
  assign pop = out_vld && out_ack;
  assign space = !count[AW] || out_ack;
  assign pend_cur = in_vld ? !in_eof : pend;
  assign eof_seen = pend_eof || (in_vld && in_eof);
  assign chunk = hold | ({{(DW-4){1'b0}}, in_dat} << {n, 2'b00});
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= PACK;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      PACK:
        if (fresh && in_vld) state_nx = in_eof ? PACK : SKIP;
        else if (done && !space) state_nx = in_eof ? FLUSH_ERR : DROP;
      DROP: if (in_vld && in_eof) state_nx = FLUSH_ERR;
      SKIP: if (in_vld && in_eof) state_nx = PACK;
      FLUSH_ERR: if (space) state_nx = eof_seen ? FLUSH_ERR : pend_cur ? DROP : PACK;
      default: state_nx = PACK;
    endcase
  end
  always_comb begin
    push = flush ? space : pack_ok && done && space;
    p_dat = flush ? '0 : chunk;
    p_size = flush ? '0 : SW'(n >> 1);
    p_eof = flush || in_eof;
    p_err = flush;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      n <= '0;
      hold <= '0;
      fresh <= 1'b1;
      pend <= 1'b0;
      pend_eof <= 1'b0;
    end else begin
      fresh <= 1'b0;
      n <= !pack_ok || done ? '0 : in_vld ? n + NW'(1) : n;
      hold <= !pack_ok || done ? '0 : in_vld ? chunk : hold;
      pend <= flush && (space ? eof_seen && pend_cur : pend_cur);
      pend_eof <= flush && !space && eof_seen;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      q_dat[wp] <= p_dat;
      q_size[wp] <= p_size;
      q_eof[wp] <= p_eof;
      q_err[wp] <= p_err;
    end
  assign out_vld = count != '0;
  assign out_dat = out_vld ? q_dat[rp] : '0;
  assign out_size = out_vld ? q_size[rp] : '0;
  assign out_eof = out_vld && q_eof[rp];
  assign out_err = out_vld && q_err[rp];
`ifdef CHUNKER_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pkt_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pkt_cnt <= push && p_eof && !p_err ? pkt_cnt + 32'd1 : pkt_cnt;
      drop_cnt <= push && p_err ? drop_cnt + 32'd1 : drop_cnt;
    end
`endif
endmodule

// File: tb/tb_rx_nibble_chunker.sv
// tb_rx_nibble_chunker: scoreboard bench with a packet-level reference model for rx_nibble_chunker.
module tb_rx_nibble_chunker;
  localparam int CB = 15;
  localparam int DEPTH = 4;
  localparam int SW = 4;
  localparam int NB = 2 * CB;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_vld = 1'b0;
  logic in_eof = 1'b0;
  logic out_ack = 1'b0;
  logic [3:0] in_dat = 4'h0;
  logic out_vld, out_eof, out_err;
  logic [8*CB-1:0] out_dat;
  logic [SW-1:0] out_size;
`ifdef CHUNKER_STATS_EN
  logic [31:0] pkt_cnt, drop_cnt;
`endif
  typedef struct {
    logic [8*CB-1:0] dat;
    logic [SW-1:0] size;
    logic eof;
    logic err;
  } chunk_t;
  chunk_t exp_q[$];
  chunk_t m_c;
  logic [3:0] nibs[$];
  int checks = 0;
  int errs = 0;
  // model view: occupancy, error chunks still owed, and per-packet discard modes
  int occ = 0;
  int owed = 0;
  int m_pkts = 0;
  int m_drops = 0;
  bit fresh = 1'b1;
  bit silent = 1'b0;
  bit discard = 1'b0;

  always #5 clk = ~clk;

  rx_nibble_chunker #(.CHUNK_BYTES(CB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_eof(in_eof),
    .out_vld(out_vld), .out_dat(out_dat), .out_size(out_size), .out_eof(out_eof), .out_err(out_err),
`ifdef CHUNKER_STATS_EN
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
`endif
    .out_ack(out_ack)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero();
    chk("rst_vld", 128'(out_vld), 128'(0));
    chk("rst_dat", 128'(out_dat), 128'(0));
    chk("rst_size", 128'(out_size), 128'(0));
    chk("rst_eof", 128'(out_eof), 128'(0));
    chk("rst_err", 128'(out_err), 128'(0));
`ifdef CHUNKER_STATS_EN
    chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
`endif
  endtask

  task automatic push_exp(input bit err, input bit eof);
    chunk_t c;
    c.dat = '0;
    if (!err) for (int k = 0; k < nibs.size(); k++) c.dat[4*k +: 4] = nibs[k];
    c.size = err ? '0 : SW'((nibs.size() + 1) / 2 - 1);
    c.eof = eof;
    c.err = err;
    exp_q.push_back(c);
    if (err) m_drops++;
    else if (eof) m_pkts++;
  endtask

  task automatic model(input logic v, input logic [3:0] d, input logic e, input logic a);
    bit pop, can, pushed;
    int owed0;
    pop = a && occ > 0;
    can = occ < DEPTH || pop;
    owed0 = owed;
    pushed = 1'b0;
    if (v) begin
      if (fresh || silent) silent = !e;
      else if (owed0 > 0 || discard) begin
        if (e) begin
          owed++;
          discard = 1'b0;
        end else discard = 1'b1;
      end else begin
        nibs.push_back(d);
        if (e || nibs.size() == NB) begin
          if (can) begin
            push_exp(1'b0, e);
            pushed = 1'b1;
          end else if (e) owed++;
          else discard = 1'b1;
          nibs.delete();
        end
      end
    end
    fresh = 1'b0;
    if (owed0 > 0 && can) begin
      push_exp(1'b1, 1'b1);
      pushed = 1'b1;
      owed--;
    end
    occ = occ + int'(pushed) - int'(pop);
  endtask

  function automatic logic ack_of(input int mode);
    return mode == 1 ? 1'b1 : mode == 2 ? ($urandom_range(3) != 0) : 1'b0;
  endfunction

  task automatic step(input logic v, input logic [3:0] d, input logic e, input logic a);
    chk("out_vld", 128'(out_vld), 128'(occ > 0));
    in_vld = v;
    in_dat = d;
    in_eof = e;
    out_ack = a;
    model(v, d, e, a);
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input int len, input int mode, input bit seq);
    for (int i = 0; i < len; i++) step(1'b1, seq ? 4'(i + 1) : 4'($urandom), i == len - 1, ack_of(mode));
  endtask

  task automatic idle(input int cyc, input int mode);
    for (int i = 0; i < cyc; i++) step(1'b0, 4'h0, 1'b0, ack_of(mode));
  endtask

  task automatic mid_reset();
    rst = 1'b1;
    occ = 0;
    owed = 0;
    discard = 1'b0;
    silent = 1'b0;
    fresh = 1'b1;
    m_pkts = 0;
    m_drops = 0;
    nibs.delete();
    exp_q.delete();
    #1 chk_zero();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_stats();
`ifdef CHUNKER_STATS_EN
    chk("pkt_cnt", 128'(pkt_cnt), 128'(m_pkts));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drops));
`endif
  endtask

  always @(negedge clk)
    if (!rst && out_vld && out_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL pop_unexpected: got dat=%0h size=%0d eof=%0b err=%0b expected nothing", out_dat, out_size, out_eof, out_err);
      end else begin
        m_c = exp_q.pop_front();
        chk("dat", 128'(out_dat), 128'(m_c.dat));
        chk("size", 128'(out_size), 128'(m_c.size));
        chk("eof", 128'(out_eof), 128'(m_c.eof));
        chk("err", 128'(out_err), 128'(m_c.err));
      end
    end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    rst = 1'b0;
    idle(3, 1);
    pkt(60, 1, 1'b0);
    idle(4, 1);
    pkt(7, 1, 1'b1);
    idle(4, 1);
    pkt(150, 0, 1'b0);
    idle(5, 0);
    idle(15, 1);
    chk_stats();
    // full queue: completion coincides with a pop
    for (int i = 0; i < 4; i++) pkt(2, 0, 1'b0);
    step(1'b1, 4'($urandom), 1'b0, 1'b0);
    step(1'b1, 4'($urandom), 1'b0, 1'b0);
    step(1'b1, 4'($urandom), 1'b1, 1'b1);
    idle(10, 1);
    for (int i = 0; i < 10; i++) step(1'b1, 4'($urandom), 1'b0, 1'b1);
    mid_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 4'($urandom), i == 19, 1'b1);
    idle(2, 1);
    pkt(30, 1, 1'b0);
    idle(5, 1);
    // overflow, second packet during the error flush, then a clean packet
    for (int i = 0; i < 4; i++) pkt(3, 0, 1'b0);
    pkt(3, 0, 1'b0);
    pkt(5, 0, 1'b0);
    idle(3, 0);
    idle(15, 1);
    pkt(20, 1, 1'b0);
    idle(5, 1);
    chk_stats();
    for (int p = 0; p < 40; p++) begin
      pkt($urandom_range(70, 8), 2, 1'b0);
      idle($urandom_range(3), 2);
    end
    idle(30, 1);
    chk("sb_empty", 128'(exp_q.size()), 128'(0));
    chk_stats();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
